// File: rtl/pb_event_decoder.sv
// Purpose : debounce N raw push-button pins into a clean level plus one-cycle
//           press / release / long-press event pulses, one independent FSM per channel.
// Latency : a pin held stable before edge 0 gives PB_PRESS/PB_RELEASE in the cycle
//           after edge DEBOUNCE_CYCLES+2 (2 sync flops + DEBOUNCE_CYCLES+1 stable samples).
// Backpressure: none; outputs are free-running pulses and levels with no handshake.
//
// Ports:
//   CLK        - system clock, rising edge
//   RST_N      - asynchronous active-low reset
//   PB_RAW     - raw button pins, asynchronous to CLK
//   PB_LEVEL   - debounced state, 1 = pressed
//   PB_PRESS   - one-cycle pulse when a press is accepted
//   PB_RELEASE - one-cycle pulse when a release is accepted
//   PB_LONG    - one-cycle pulse when an accepted press has been held LONG_CYCLES
module pb_event_decoder #(
  parameter int NUM_PB          = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_PB-1:0] PB_RAW,
  output logic [NUM_PB-1:0] PB_LEVEL,
  output logic [NUM_PB-1:0] PB_PRESS,
  output logic [NUM_PB-1:0] PB_RELEASE,
  output logic [NUM_PB-1:0] PB_LONG
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DB_PRESS  = 3'd1,
    ST_HELD      = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_DB_REL    = 3'd4
  } state_e;

  // Pin level that means "not pressed"; the synchronizer resets to it so that
  // coming out of reset never looks like an edge.
  localparam logic [NUM_PB-1:0] IDLE_PIN  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]  DB_TERM   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit                LONG_EN   = (LONG_CYCLES != 0);
  localparam logic [CNT_W-1:0]  LONG_TERM = LONG_EN ? CNT_W'(LONG_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // ---------------------------------------------------------------------------
  // 2-FF synchronizer for all channels, then normalize to 1 = pressed
  // ---------------------------------------------------------------------------
  logic [NUM_PB-1:0] sync1_q;
  logic [NUM_PB-1:0] sync2_q;
  logic [NUM_PB-1:0] pressed;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
    end else begin
      sync1_q <= PB_RAW;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // ---------------------------------------------------------------------------
  // Per-channel debounce / event FSM
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               long_done_q;
    logic               long_done_d;
    logic               level_q;
    logic               level_d;
    logic               press_q;
    logic               press_d;
    logic               rel_q;
    logic               rel_d;
    logic               long_q;
    logic               long_d;
    logic               s;

    assign s = pressed[g];

    // Saturating increment: the terminal compares normally stop the counter,
    // this only matters in HELD when the long timer is disabled.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d = ST_DB_PRESS;
            cnt_d   = '0;
          end
        end

        ST_DB_PRESS: begin
          if (!s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_TERM) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_HELD: begin
          if (!s) begin
            state_d = ST_DB_REL;
            cnt_d   = '0;
          end else if (LONG_EN && (cnt_q == LONG_TERM)) begin
            state_d     = ST_LONG_HELD;
            cnt_d       = '0;
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        // Long pulse already issued for this press; just wait for release.
        ST_LONG_HELD: begin
          if (!s) begin
            state_d = ST_DB_REL;
            cnt_d   = '0;
          end
        end

        ST_DB_REL: begin
          if (s) begin
            // Release was a glitch. Returning to HELD restarts the long timer;
            // a press that already fired LONG goes back to LONG_HELD instead.
            state_d = long_done_q ? ST_LONG_HELD : ST_HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_TERM) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            rel_d       = 1'b1;
            level_d     = 1'b0;
            long_done_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          long_done_d = 1'b0;
          level_d     = 1'b0;
        end
      endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        long_q      <= long_d;
      end
    end

    assign PB_LEVEL[g]   = level_q;
    assign PB_PRESS[g]   = press_q;
    assign PB_RELEASE[g] = rel_q;
    assign PB_LONG[g]    = long_q;
  end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Purpose : self-checking bench for pb_event_decoder; an active-low and an
//           active-high instance see the same button activity (inverted pins)
//           and both are compared each cycle with a run-length reference model.
// Latency : n/a (bench). Backpressure: n/a.
module tb_pb_event_decoder;

  localparam int DB = 4;
  localparam int LG = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pb_raw = 2'b11;
  logic [1:0] pb_raw_hi;
  logic [1:0] lvl1, prs1, rel1, lng1;
  logic [1:0] lvl2, prs2, rel2, lng2;
  logic [7:0] obs1, obs2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign pb_raw_hi = ~pb_raw;
  assign obs1 = {lvl1, prs1, rel1, lng1};
  assign obs2 = {lvl2, prs2, rel2, lng2};

  pb_event_decoder #(
    .NUM_PB(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .CNT_W(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .PB_RAW(pb_raw),
    .PB_LEVEL(lvl1), .PB_PRESS(prs1), .PB_RELEASE(rel1), .PB_LONG(lng1)
  );

  pb_event_decoder #(
    .NUM_PB(2), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .CNT_W(8)
  ) dut_hi (
    .CLK(clk), .RST_N(rst_n), .PB_RAW(pb_raw_hi),
    .PB_LEVEL(lvl2), .PB_PRESS(prs2), .PB_RELEASE(rel2), .PB_LONG(lng2)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a level flips once the synchronized input has disagreed
  // with it for DB+1 consecutive samples; the long pulse fires when a press has
  // been continuously sampled pressed for LG samples since acceptance (or since
  // the last aborted release), once per press.
  // ---------------------------------------------------------------------------
  logic [1:0] m_s1, m_s2;
  bit         m_lvl  [2];
  int         m_run  [2];
  int         m_age  [2];
  bit         m_done [2];
  logic [7:0] exp_vec;

  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0] pr, rl, lg, lv;
    bit s, l, d;
    int r, a;
    if (!rst_n) begin
      m_s1    <= 2'b00;
      m_s2    <= 2'b00;
      exp_vec <= 8'h00;
      for (int ch = 0; ch < 2; ch++) begin
        m_lvl[ch]  <= 1'b0;
        m_run[ch]  <= 0;
        m_age[ch]  <= 0;
        m_done[ch] <= 1'b0;
      end
    end else begin
      pr = 2'b00; rl = 2'b00; lg = 2'b00; lv = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        s = m_s2[ch]; l = m_lvl[ch]; r = m_run[ch]; a = m_age[ch]; d = m_done[ch];
        if (s != l) begin
          r = r + 1;
          if (r == DB + 1) begin
            l = s;
            r = 0;
            if (s) begin pr[ch] = 1'b1; a = 0; end
            else   begin rl[ch] = 1'b1; d = 1'b0; end
          end
        end else begin
          if (l) begin
            if (r != 0) a = 0;
            else        a = a + 1;
            if (!d && a == LG) begin lg[ch] = 1'b1; d = 1'b1; end
          end
          r = 0;
        end
        lv[ch] = l;
        m_lvl[ch]  <= l;
        m_run[ch]  <= r;
        m_age[ch]  <= a;
        m_done[ch] <= d;
      end
      exp_vec <= {lv, pr, rl, lg};
      m_s2    <= m_s1;
      m_s1    <= ~pb_raw;
    end
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    pb_raw = 2'b11;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs1 !== 8'h00 || obs2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs dut=%b dut_hi=%b expected=%b", obs1, obs2, 8'h00);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== 8'h00 || obs2 !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, 8'h00);
      end
    end
  endtask

  task automatic test_clean_press();
    pb_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (prs1 !== ((k == 6) ? 2'b01 : 2'b00) || prs2 !== ((k == 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL clean_press_timing k=%0d dut=%b dut_hi=%b expected=%b",
                 k, prs1, prs2, (k == 6) ? 2'b01 : 2'b00);
      end
      n_checks++;
      if (obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        $display("FAIL clean_press_model k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
    n_checks++;
    if (lvl1 !== 2'b01 || lvl2 !== 2'b01) begin
      n_fail++;
      $display("FAIL clean_press_level dut=%b dut_hi=%b expected=%b", lvl1, lvl2, 2'b01);
    end
    pb_raw[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        $display("FAIL clean_release_model k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      if (k < 20 && (k % 2) == 0) pb_raw[0] = ~pb_raw[0];
      @(negedge clk);
      n_checks++;
      if (obs1 !== 8'h00 || obs2 !== 8'h00) begin
        n_fail++;
        $display("FAIL bounce_silent k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, 8'h00);
      end
    end
  endtask

  task automatic test_long_press();
    int press_at = -1;
    int long_at  = -1;
    int nlong    = 0;
    int rel_at   = -1;
    pb_raw[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (prs1[0]) press_at = k;
      if (lng1[0]) begin long_at = k; nlong++; end
      n_checks++;
      if (obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        $display("FAIL long_model k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
    n_checks++;
    if (press_at != 6 || long_at != 26 || nlong != 1) begin
      n_fail++;
      $display("FAIL long_timing press_at=%0d long_at=%0d nlong=%0d expected 6/26/1",
               press_at, long_at, nlong);
    end
    pb_raw[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rel1[0]) rel_at = k;
      n_checks++;
      if (obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        $display("FAIL long_rel_model k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
    n_checks++;
    if (rel_at != 6 || lvl1 !== 2'b00) begin
      n_fail++;
      $display("FAIL long_release rel_at=%0d level=%b expected 6/00", rel_at, lvl1);
    end
  endtask

  task automatic test_release_glitch();
    int nlong  = 0;
    int nrel   = 0;
    int rel_at = -1;
    pb_raw[0] = 1'b0;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      pb_raw[0] = (k < 2);
      @(negedge clk);
      if (lng1[0]) nlong++;
      if (rel1[0]) nrel++;
      n_checks++;
      if (obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        $display("FAIL glitch_model k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
    n_checks++;
    if (nlong != 0 || nrel != 0 || lvl1[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_ignored nlong=%0d nrel=%0d level=%b expected 0/0/1", nlong, nrel, lvl1[0]);
    end
    pb_raw[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (lng1[0]) nlong++;
      if (rel1[0]) begin nrel++; rel_at = k; end
    end
    n_checks++;
    if (nlong != 0 || nrel != 1 || rel_at != 6) begin
      n_fail++;
      $display("FAIL glitch_real_release nlong=%0d nrel=%0d rel_at=%0d expected 0/1/6",
               nlong, nrel, rel_at);
    end
  endtask

  task automatic test_reset_mid_press();
    pb_raw[0] = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (lvl1 !== 2'b01 || lvl2 !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_level_before dut=%b dut_hi=%b expected=%b", lvl1, lvl2, 2'b01);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs1 !== 8'h00 || obs2 !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async_clear dut=%b dut_hi=%b expected=%b", obs1, obs2, 8'h00);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (prs1 !== ((k == 6) ? 2'b01 : 2'b00) || obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_repress k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
    pb_raw[0] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_both_channels();
    pb_raw = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (prs1 !== ((k == 6) ? 2'b11 : 2'b00) || prs2 !== ((k == 6) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL both_press k=%0d dut=%b dut_hi=%b expected=%b",
                 k, prs1, prs2, (k == 6) ? 2'b11 : 2'b00);
      end
    end
    pb_raw = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (rel1 !== ((k == 6) ? 2'b11 : 2'b00) || rel2 !== ((k == 6) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL both_release k=%0d dut=%b dut_hi=%b expected=%b",
                 k, rel1, rel2, (k == 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_random();
    int hold [2];
    int errs = 0;
    hold[0] = 0;
    hold[1] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          pb_raw[ch] = $urandom_range(0, 1);
          hold[ch]   = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
        end else begin
          hold[ch] = hold[ch] - 1;
        end
      end
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec || obs2 !== exp_vec) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_model k=%0d dut=%b dut_hi=%b expected=%b", k, obs1, obs2, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_reset_mid_press();
    test_both_channels();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
